// File: rtl/noc_pkg.sv
// Shared definitions for the tree NoC nodes (merge and split).
// Optional statistics in merge2_arb are enabled by defining MERGE2_ARB_STATS_EN.
package noc_pkg;

  localparam int DATA_W   = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
  localparam int STAT_W   = 16;

  typedef logic [DATA_W-1:0] flit_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Source token carried alongside each forwarded flit
  typedef enum logic {SRC_IN0, SRC_IN1} src_t;

  // Occupancy of the one-entry output register
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  // Destination address field of a flit; nodes route on it but never modify it
  function automatic addr_t flit_addr(input flit_t f);
    return f[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/merge2_arb_rr_arb2.sv
// Two-input round-robin arbiter. Holds the priority flop; priority moves to
// the losing input only when a grant is actually consumed (advance).
module rr_arb2
  import noc_pkg::*;
#(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_reg;
  logic prio_next;

  // Grant selection: a lone requester wins, contention goes to prio
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Priority update: the loser of a consumed grant holds priority next
  always_comb begin
    prio_next = prio_reg;
    if (advance) begin
      prio_next = ~grant[1];
    end
  end

  // Priority register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prio_reg <= INIT_PRIO;
    end else begin
      prio_reg <= prio_next;
    end
  end

endmodule

// File: rtl/merge2_arb.sv
// Two-to-one merge node: round-robin arbitration of In0/In1 into a one-entry
// output register that forwards each flit unchanged with a source token.
// Define MERGE2_ARB_STATS_EN to add per-input and conflict counters.
module merge2_arb
  import noc_pkg::*;
#(
  parameter int   DATA_W    = noc_pkg::DATA_W,
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel
`ifdef MERGE2_ARB_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  out_state_t        state_reg;
  out_state_t        state_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;
  src_t              sel_reg;
  src_t              sel_next;

  logic [1:0] req;
  logic [1:0] grant;
  logic       slot_free;
  logic       accept;

  assign req = {in1_valid, in0_valid};

  rr_arb2 #(
    .INIT_PRIO (INIT_PRIO)
  ) u_arb (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (req),
    .advance (accept),
    .grant   (grant)
  );

  // Handshake: the slot frees when empty or draining this cycle; readies are
  // held low during reset since the emptied register would otherwise look free
  always_comb begin
    slot_free = (state_reg == OUT_EMPTY) || out_ready;
    in0_ready = slot_free && grant[0] && !RESET;
    in1_ready = slot_free && grant[1] && !RESET;
    accept    = in0_ready || in1_ready;
  end

  // Output register next state: refill on accept, empty on drain, else hold
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    case (state_reg)
      OUT_EMPTY: begin
        if (accept) state_next = OUT_FULL;
      end
      OUT_FULL: begin
        if (accept)         state_next = OUT_FULL;
        else if (out_ready) state_next = OUT_EMPTY;
      end
      default: state_next = OUT_EMPTY;
    endcase
    if (accept) begin
      data_next = in1_ready ? in1_data : in0_data;
      sel_next  = in1_ready ? SRC_IN1 : SRC_IN0;
    end
  end

  // Output register state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= OUT_EMPTY;
      data_reg  <= '0;
      sel_reg   <= SRC_IN0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
    end
  end

  assign out_valid = (state_reg == OUT_FULL);
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;

`ifdef MERGE2_ARB_STATS_EN
  logic [15:0] cnt0_reg;
  logic [15:0] cnt1_reg;
  logic [15:0] conflict_reg;

  // Traffic counters; all wrap naturally at 16 bits
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt0_reg     <= '0;
      cnt1_reg     <= '0;
      conflict_reg <= '0;
    end else begin
      if (in0_ready) cnt0_reg <= cnt0_reg + 16'd1;
      if (in1_ready) cnt1_reg <= cnt1_reg + 16'd1;
      if (in0_valid && in1_valid && slot_free) conflict_reg <= conflict_reg + 16'd1;
    end
  end

  assign cnt0         = cnt0_reg;
  assign cnt1         = cnt1_reg;
  assign conflict_cnt = conflict_reg;
`endif

endmodule

// File: tb/tb_merge2_arb.sv
// Directed testbench for merge2_arb with hand-computed expectations.
// Works with or without MERGE2_ARB_STATS_EN.
module tb_merge2_arb;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       in0_valid, in0_ready;
  logic [8:0] in0_data;
  logic       in1_valid, in1_ready;
  logic [8:0] in1_data;
  logic       out_valid, out_ready;
  logic [8:0] out_data;
  logic       out_sel;
`ifdef MERGE2_ARB_STATS_EN
  logic [15:0] cnt0, cnt1, conflict_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  merge2_arb dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef MERGE2_ARB_STATS_EN
    ,
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("ok   %s obs=%h exp=%h", tag, obs, exp);
    end else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [8:0] d, input logic s);
    chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v});
    chk({tag, ".out_data"},  {7'd0, out_data},   {7'd0, d});
    chk({tag, ".out_sel"},   {15'd0, out_sel},   {15'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".in0_ready"}, {15'd0, in0_ready}, {15'd0, r0});
    chk({tag, ".in1_ready"}, {15'd0, in1_ready}, {15'd0, r1});
  endtask

  logic [8:0] exp_seq [8] = '{9'h001, 9'h101, 9'h002, 9'h102, 9'h003, 9'h103, 9'h004, 9'h104};

  initial begin
    RESET = 1'b1;
    in0_valid = 0; in0_data = '0;
    in1_valid = 0; in1_data = '0;
    out_ready = 0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;

    // Reset then idle
    chk_out("rst", 1'b0, 9'h000, 1'b0);
    chk_rdy("rst", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("idle", 1'b0, 9'h000, 1'b0);
      chk_rdy("idle", 1'b0, 1'b0);
    end

    // Single source In0
    in0_valid = 1; in0_data = 9'h0C3; out_ready = 1;
    #1 chk_rdy("single0", 1'b1, 1'b0);
    step();
    in0_valid = 0;
    #1 chk_out("single0", 1'b1, 9'h0C3, 1'b0);
    step();
    chk_out("drain0", 1'b0, 9'h0C3, 1'b0);

    // Single source In1 (returns priority to In0)
    in1_valid = 1; in1_data = 9'h055;
    #1 chk_rdy("single1", 1'b0, 1'b1);
    step();
    in1_valid = 0;
    #1 chk_out("single1", 1'b1, 9'h055, 1'b1);
    step();

    // Contention: strict alternation, one flit per cycle
    begin
      int i0 = 0;
      int i1 = 0;
      for (int k = 0; k < 8; k++) begin
        in0_valid = (i0 < 4); in0_data = 9'h001 + 9'(i0);
        in1_valid = (i1 < 4); in1_data = 9'h101 + 9'(i1);
        #1 chk_rdy("cont", (k % 2 == 0), (k % 2 == 1));
        step();
        if (k % 2 == 0) i0++; else i1++;
        chk_out("cont", 1'b1, exp_seq[k], (k % 2 == 1));
      end
      in0_valid = 0; in1_valid = 0;
    end
    step();
    chk_out("cont_drain", 1'b0, 9'h104, 1'b1);

    // Backpressure: FULL with 1E0, downstream stalled, In1 waiting
    in0_valid = 1; in0_data = 9'h1E0;
    step();
    in0_valid = 0; out_ready = 0;
    in1_valid = 1; in1_data = 9'h1AB;
    for (int i = 0; i < 4; i++) begin
      #1 chk_rdy("bp", 1'b0, 1'b0);
      chk_out("bp", 1'b1, 9'h1E0, 1'b0);
      step();
    end
    out_ready = 1;
    #1 chk_rdy("bp_release", 1'b0, 1'b1);
    step();
    in1_valid = 0;
    #1 chk_out("bp_release", 1'b1, 9'h1AB, 1'b1);

    // Priority persistence: In1 won last, idle, then contention favours In0
    repeat (4) step();
    chk_out("persist_idle", 1'b0, 9'h1AB, 1'b1);
    in0_valid = 1; in0_data = 9'h0AA;
    in1_valid = 1; in1_data = 9'h1BB;
    #1 chk_rdy("persist", 1'b1, 1'b0);
    step();
    in0_data = 9'h0CC;
    out_ready = 0;
    #1 chk_out("persist", 1'b1, 9'h0AA, 1'b0);
    chk_rdy("persist_full", 1'b0, 1'b0);

    // Reset mid-operation: priority now favours In1, reset restores In0
    #2 RESET = 1'b1;
    #1 chk_out("rst_mid", 1'b0, 9'h000, 1'b0);
    chk_rdy("rst_mid", 1'b0, 1'b0);
`ifdef MERGE2_ARB_STATS_EN
    chk("rst_mid.cnt0", cnt0, 16'd0);
    chk("rst_mid.cnt1", cnt1, 16'd0);
    chk("rst_mid.conflict_cnt", conflict_cnt, 16'd0);
`endif
    step();
    RESET = 1'b0;
    out_ready = 1;
    #1 chk_rdy("post_rst", 1'b1, 1'b0);
    step();
    in0_valid = 0; in1_valid = 0;
    #1 chk_out("post_rst", 1'b1, 9'h0CC, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time bound in case the sequence stalls
  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
